key_input_conditioner: RTL and testbench

KEY_INPUT_CONDITIONER -- requirements
Module: key_input_conditioner

---
 rtl/key_cond_pkg.sv | 16 +
 rtl/key_input_conditioner_debounce.sv | 89 ++++++++
 rtl/key_input_conditioner.sv | 127 ++++++++++++
 tb/tb_key_input_conditioner.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/key_cond_pkg.sv
// Shared types and default constants for the key input conditioner.
package key_cond_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_GAP   = 2'd2
   } issue_state_e;

   localparam int DEF_NKEYS           = 4;
   localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
   localparam int DEF_REPEAT_DELAY    = 25_000_000;
   localparam int DEF_REPEAT_PERIOD   = 10_000_000;
   localparam int DEF_GAP_CYCLES      = 2;

endpackage

// File: rtl/key_input_conditioner_debounce.sv
// One key: 2-flop synchronizer, debounce filter and auto-repeat timer.
// event_o is a registered one-cycle pulse on a debounced press or a repeat tick.
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int REPEAT_DELAY    = 20,
   parameter int REPEAT_PERIOD   = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic key_n_i,
   input  logic repeat_en_i,
   output logic level_o,
   output logic event_o
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW = $clog2(RMAX) + 1;
   localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

   logic          sync1_q, sync2_q;
   logic          held_raw_s;
   logic          stable_q, stable_d;
   logic [DW-1:0] db_cnt_q, db_cnt_d;
   logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
   logic          rpt_phase_q, rpt_phase_d;
   logic          event_q, event_d;

   assign held_raw_s = ~sync2_q;

   // Debounce and repeat next-state; repeat runs only while held before and after this edge
   always_comb begin
      stable_d    = stable_q;
      db_cnt_d    = db_cnt_q;
      rpt_cnt_d   = rpt_cnt_q;
      rpt_phase_d = rpt_phase_q;
      event_d     = 1'b0;
      if (held_raw_s != stable_q) begin
         if (db_cnt_q == DB_LAST) begin
            stable_d = held_raw_s;
            db_cnt_d = '0;
            event_d  = held_raw_s;
         end else begin
            db_cnt_d = db_cnt_q + DW'(1);
         end
      end else begin
         db_cnt_d = '0;
      end
      if (stable_q && stable_d && repeat_en_i) begin
         if (rpt_cnt_q == (rpt_phase_q ? RP_LAST : RD_LAST)) begin
            rpt_cnt_d   = '0;
            rpt_phase_d = 1'b1;
            event_d     = 1'b1;
         end else begin
            rpt_cnt_d = rpt_cnt_q + RW'(1);
         end
      end else begin
         rpt_cnt_d   = '0;
         rpt_phase_d = 1'b0;
      end
   end

   // State registers; reset returns everything to the released condition
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q     <= 1'b1;
         sync2_q     <= 1'b1;
         stable_q    <= 1'b0;
         db_cnt_q    <= '0;
         rpt_cnt_q   <= '0;
         rpt_phase_q <= 1'b0;
         event_q     <= 1'b0;
      end else begin
         sync1_q     <= key_n_i;
         sync2_q     <= sync1_q;
         stable_q    <= stable_d;
         db_cnt_q    <= db_cnt_d;
         rpt_cnt_q   <= rpt_cnt_d;
         rpt_phase_q <= rpt_phase_d;
         event_q     <= event_d;
      end
   end

   assign level_o = stable_q;
   assign event_o = event_q;

endmodule

// File: rtl/key_input_conditioner.sv
// Debounced, auto-repeating key conditioner issuing one-hot press pulses,
// highest key first, with a fixed idle gap after every pulse.
module key_input_conditioner
   import key_cond_pkg::*;
#(
   parameter int NKEYS           = DEF_NKEYS,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
   parameter int GAP_CYCLES      = DEF_GAP_CYCLES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NKEYS-1:0] key_n,
   input  logic             busy,
   input  logic             repeat_en,
   output logic [NKEYS-1:0] key_pressed,
   output logic             refresh,
   output logic [NKEYS-1:0] key_level
);

   localparam int GW = $clog2(GAP_CYCLES) + 1;
   localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   logic [NKEYS-1:0] level_s, event_s;
   logic [NKEYS-1:0] pending_q, pending_d;
   logic [NKEYS-1:0] issue_mask_s, clr_mask_s;
   logic             any_pend_s, may_issue_s, issue_now_s;
   issue_state_e     state_q;
   logic [GW-1:0]    gap_cnt_q;
   logic [NKEYS-1:0] key_pressed_q;
   logic             refresh_q;

   for (genvar g = 0; g < NKEYS; g++) begin : g_key
      key_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD)
      ) u_key (
         .clk         (clk),
         .rst         (rst),
         .key_n_i     (key_n[g]),
         .repeat_en_i (repeat_en),
         .level_o     (level_s[g]),
         .event_o     (event_s[g])
      );
   end

   // Priority select: the highest-index pending key overrides lower ones
   always_comb begin
      issue_mask_s = '0;
      for (int i = 0; i < NKEYS; i++) begin
         if (pending_q[i]) begin
            issue_mask_s = NKEYS'(1) << i;
         end else begin
            issue_mask_s = issue_mask_s;
         end
      end
   end

   // The last gap cycle makes the idle decision itself so the gap is exactly GAP_CYCLES long
   assign any_pend_s  = |pending_q;
   assign may_issue_s = (state_q == ST_IDLE) || ((state_q == ST_GAP) && (gap_cnt_q == GAP_LAST));
   assign issue_now_s = may_issue_s && any_pend_s && !busy;
   assign clr_mask_s  = issue_now_s ? issue_mask_s : '0;
   assign pending_d   = (pending_q & ~clr_mask_s) | event_s;

   // Pending bits: a new event in the same cycle as the clear keeps the bit set
   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q <= '0;
      end else begin
         pending_q <= pending_d;
      end
   end

   // Issuer FSM with registered pulse outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         gap_cnt_q     <= '0;
         key_pressed_q <= '0;
         refresh_q     <= 1'b0;
      end else begin
         key_pressed_q <= '0;
         refresh_q     <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (issue_now_s) begin
                  state_q       <= ST_ISSUE;
                  key_pressed_q <= issue_mask_s;
                  refresh_q     <= 1'b1;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_ISSUE: begin
               state_q   <= ST_GAP;
               gap_cnt_q <= '0;
            end
            ST_GAP: begin
               if (gap_cnt_q == GAP_LAST) begin
                  gap_cnt_q <= '0;
                  if (issue_now_s) begin
                     state_q       <= ST_ISSUE;
                     key_pressed_q <= issue_mask_s;
                     refresh_q     <= 1'b1;
                  end else begin
                     state_q <= ST_IDLE;
                  end
               end else begin
                  gap_cnt_q <= gap_cnt_q + GW'(1);
               end
            end
            default: begin
               state_q   <= ST_IDLE;
               gap_cnt_q <= '0;
            end
         endcase
      end
   end

   assign key_pressed = key_pressed_q;
   assign refresh     = refresh_q;
   assign key_level   = level_s;

endmodule

// File: tb/tb_key_input_conditioner.sv
// Scoreboard bench: expected pulses (cycle, value) are queued when stimulus is
// driven and popped by a monitor whenever the DUT emits a pulse.
module tb_key_input_conditioner;

   logic       clk;
   logic       rst;
   logic [3:0] key_n;
   logic       busy;
   logic       repeat_en;
   logic [3:0] key_pressed;
   logic       refresh;
   logic [3:0] key_level;

   typedef struct {
      int         cyc;
      logic [3:0] val;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;
   int   c;

   key_input_conditioner #(
      .NKEYS           (4),
      .DEBOUNCE_CYCLES (4),
      .REPEAT_DELAY    (20),
      .REPEAT_PERIOD   (8),
      .GAP_CYCLES      (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .key_n       (key_n),
      .busy        (busy),
      .repeat_en   (repeat_en),
      .key_pressed (key_pressed),
      .refresh     (refresh),
      .key_level   (key_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic push_exp(input int at_cyc, input logic [3:0] val);
      exp_t e;
      e.cyc = at_cyc;
      e.val = val;
      exp_q.push_back(e);
   endtask

   // Monitor: every pulse must match the head of the scoreboard in value and cycle
   always @(negedge clk) begin
      if ((|key_pressed) === 1'b1 || refresh === 1'b1) begin
         check_eq("refresh_eq_or", {31'd0, refresh}, {31'd0, |key_pressed});
         check_eq("onehot", $countones(key_pressed), 1);
         if (exp_q.size() == 0) begin
            check_eq("unexpected_pulse", {28'd0, key_pressed}, 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check_eq("pulse_val", {28'd0, key_pressed}, {28'd0, mon_e.val});
            check_eq("pulse_cyc", cyc, mon_e.cyc);
         end
      end
   end

   initial begin
      rst       = 1'b1;
      key_n     = 4'hF;
      busy      = 1'b0;
      repeat_en = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_key_pressed", {28'd0, key_pressed}, 32'd0);
      check_eq("rst_refresh", {31'd0, refresh}, 32'd0);
      check_eq("rst_key_level", {28'd0, key_level}, 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Single key, pulse D+4 edges after first low sample, no repeat
      c = cyc;
      key_n[1] = 1'b0;
      push_exp(c + 8, 4'b0010);
      repeat (30) @(negedge clk);
      check_eq("s1_level", {28'd0, key_level}, 32'h2);
      check_eq("s1_drained", exp_q.size(), 0);
      key_n = 4'hF;
      repeat (10) @(negedge clk);
      check_eq("s1_released", {28'd0, key_level}, 32'h0);

      // Bouncing input never settles long enough
      for (int i = 0; i < 20; i++) begin
         key_n[0] = ~key_n[0];
         repeat (2) @(negedge clk);
         check_eq("s2_level", {31'd0, key_level[0]}, 32'd0);
      end
      key_n = 4'hF;
      repeat (10) @(negedge clk);

      // Simultaneous presses issue highest first with 2 idle cycles between
      c = cyc;
      key_n = 4'b0010;
      push_exp(c + 8, 4'b1000);
      push_exp(c + 11, 4'b0100);
      push_exp(c + 14, 4'b0001);
      repeat (30) @(negedge clk);
      check_eq("s3_drained", exp_q.size(), 0);
      key_n = 4'hF;
      repeat (10) @(negedge clk);

      // Busy holds the pulse until it drops
      busy = 1'b1;
      key_n = 4'b1011;
      repeat (20) @(negedge clk);
      busy = 1'b0;
      push_exp(cyc + 1, 4'b0100);
      repeat (20) @(negedge clk);
      check_eq("s4_drained", exp_q.size(), 0);
      key_n = 4'hF;
      repeat (10) @(negedge clk);

      // Auto-repeat on key 3 held for 60 cycles
      repeat_en = 1'b1;
      c = cyc;
      key_n = 4'b0111;
      push_exp(c + 8, 4'b1000);
      for (int k = 0; k < 5; k++) push_exp(c + 28 + 8 * k, 4'b1000);
      repeat (60) @(negedge clk);
      key_n = 4'hF;
      repeat (30) @(negedge clk);
      check_eq("s5_drained", exp_q.size(), 0);
      repeat_en = 1'b0;
      repeat (5) @(negedge clk);

      // Reset during ISSUE drops pending key 1; held keys re-debounce as fresh presses
      c = cyc;
      key_n = 4'b0101;
      push_exp(c + 8, 4'b1000);
      repeat (8) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_eq("s6_pressed_after_rst", {28'd0, key_pressed}, 32'd0);
      check_eq("s6_refresh_after_rst", {31'd0, refresh}, 32'd0);
      check_eq("s6_level_after_rst", {28'd0, key_level}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      push_exp(c + 18, 4'b1000);
      push_exp(c + 21, 4'b0010);
      repeat (30) @(negedge clk);
      check_eq("s6_drained", exp_q.size(), 0);
      key_n = 4'hF;
      repeat (15) @(negedge clk);

      check_eq("final_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
